// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first serial-to-byte receiver, aligned on COM_CHAR. Rev 1.0
// Optional macro SYNC_LOSS_EN drops lock after MAX_GAP consecutive non-COM bytes.
`default_nettype none

module serial_paralelo #(
  parameter logic [7:0] COM_CHAR   = 8'hBC,
  parameter int         LOCK_COUNT = 4
`ifdef SYNC_LOSS_EN
  ,
  parameter int         MAX_GAP    = 16
`endif
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] out_paralelo,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  state_t     state;
  logic [6:0] sr;
  logic [2:0] bc;
  logic [3:0] com_cnt;
  logic [7:0] window;
  logic       boundary;
  logic       is_com;

  // The window includes the bit being sampled now, so a byte is usable on its 8th edge.
  assign window   = {sr, in_serial};
  assign boundary = (bc == 3'd7);
  assign is_com   = (window == COM_CHAR);

`ifdef SYNC_LOSS_EN
  localparam int               GAP_W   = $clog2(MAX_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(MAX_GAP);
  logic [GAP_W-1:0] gap;
`endif

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state        <= ST_SEARCH;
      sr           <= 7'd0;
      bc           <= 3'd0;
      com_cnt      <= 4'd0;
      out_paralelo <= 8'h00;
      valid_out    <= 1'b0;
      active       <= 1'b0;
`ifdef SYNC_LOSS_EN
      gap          <= '0;
`endif
    end else begin
      sr        <= window[6:0];
      bc        <= bc + 3'd1;
      valid_out <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (is_com) begin
            // Restart the bit counter so the next boundary lands 8 bits after this COM.
            bc      <= 3'd0;
            com_cnt <= 4'd1;
            if (LOCK_CNT == 4'd1) begin
              state  <= ST_ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt + 4'd1 == LOCK_CNT) begin
                state  <= ST_ACTIVE;
                active <= 1'b1;
              end
            end else begin
              com_cnt <= 4'd0;
              state   <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          if (boundary) begin
            out_paralelo <= window;
            valid_out    <= !is_com;
`ifdef SYNC_LOSS_EN
            if (is_com) begin
              gap <= '0;
            end else if (gap + GAP_W'(1) == GAP_LIM) begin
              gap     <= '0;
              com_cnt <= 4'd0;
              active  <= 1'b0;
              state   <= ST_SEARCH;
            end else begin
              gap <= gap + GAP_W'(1);
            end
`endif
          end
        end
        default: begin
          state  <= ST_SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: directed + randomized checks of serial_paralelo against a bit-record model.
`default_nettype none

module tb_serial_paralelo;

  localparam logic [7:0] COM      = 8'hBC;
  localparam int         LOCK     = 4;
  localparam int         MAX_GAP  = 16;
  localparam int         MAXB     = 4096;
`ifdef SYNC_LOSS_EN
  localparam bit         LOSS_EN  = 1'b1;
`else
  localparam bit         LOSS_EN  = 1'b0;
`endif

  logic       clk_32f;
  logic       reset;
  logic       in_serial;
  logic [7:0] out_paralelo;
  logic       valid_out;
  logic       active;

  int checks;
  int errors;
  int pulses;
  int n;
  logic bits [0:MAXB];

  serial_paralelo dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .in_serial    (in_serial),
    .out_paralelo (out_paralelo),
    .valid_out    (valid_out),
    .active       (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Byte formed by bits k-7..k of the record since reset (bits before 1 read as 0).
  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = k - 7; i <= k; i++) b = {b[6:0], (i >= 1) ? bits[i] : 1'b0};
    return b;
  endfunction

  // Expected outputs after edge n, derived by scanning the whole bit record.
  function automatic void model(output logic [7:0] e_out, output logic e_val, output logic e_act);
    int pos, k, j, e, t, gap;
    logic [7:0] b;
    bit lost;
    e_out = 8'h00;
    e_val = 1'b0;
    e_act = 1'b0;
    pos   = 1;
    while (pos <= n) begin
      k = pos;
      while (k <= n && byte_at(k) != COM) k++;
      if (k > n) break;
      j = 1;
      e = k;
      while (j < LOCK && e + 8 <= n && byte_at(e + 8) == COM) begin
        j++;
        e += 8;
      end
      if (j < LOCK) begin
        if (e + 8 <= n) begin
          pos = e + 9;
          continue;
        end
        break;
      end
      t    = e;
      gap  = 0;
      lost = 1'b0;
      while (t + 8 <= n) begin
        t += 8;
        b = byte_at(t);
        e_out = b;
        gap = (b == COM) ? 0 : gap + 1;
        if (LOSS_EN && gap == MAX_GAP) begin
          lost = 1'b1;
          break;
        end
      end
      if (!lost) begin
        e_act = 1'b1;
        e_val = (t == n) && (t > e) && (byte_at(t) != COM);
        break;
      end
      if (t == n) begin
        e_val = 1'b1;
        break;
      end
      pos = t + 1;
    end
  endfunction

  task automatic check_all();
    logic [7:0] e_out;
    logic e_val, e_act;
    model(e_out, e_val, e_act);
    checks++;
    assert (out_paralelo === e_out) else begin
      errors++;
      $error("FAIL out_paralelo@%0d: observed %h expected %h", n, out_paralelo, e_out);
    end
    checks++;
    assert (valid_out === e_val) else begin
      errors++;
      $error("FAIL valid_out@%0d: observed %b expected %b", n, valid_out, e_val);
    end
    checks++;
    assert (active === e_act) else begin
      errors++;
      $error("FAIL active@%0d: observed %b expected %b", n, active, e_act);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    in_serial = b;
    @(posedge clk_32f);
    #1;
    n++;
    bits[n] = b;
    if (valid_out === 1'b1) pulses++;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      in_serial = 1'($urandom);
      @(posedge clk_32f);
      #1;
      n = 0;
      check_all();
    end
    reset = 1'b0;
    n = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulses    = 0;
    n         = 0;
    reset     = 1'b1;
    in_serial = 1'b0;

    // Reset with random serial input
    do_reset(3);

    // Clean lock, then two data bytes
    repeat (4) send_byte(COM);
    check_val("lock_edge32", int'(active), 1);
    send_byte(8'hA5);
    check_val("byte_A5", int'(out_paralelo), 8'hA5);
    check_val("valid_A5", int'(valid_out), 1);
    send_byte(8'h3C);
    check_val("byte_3C", int'(out_paralelo), 8'h3C);
    check_val("valid_3C", int'(valid_out), 1);

    // Misaligned start
    do_reset(1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4) send_byte(COM);
    check_val("misalign_n", n, 35);
    check_val("misalign_lock", int'(active), 1);
    send_byte(8'h5A);
    check_val("misalign_5A", int'(out_paralelo), 8'h5A);
    check_val("misalign_valid", int'(valid_out), 1);

    // Broken lock sequence
    do_reset(1);
    send_byte(COM); send_byte(COM); send_byte(8'h00);
    repeat (3) send_byte(COM);
    check_val("broken_not_yet", int'(active), 0);
    send_byte(COM);
    check_val("broken_lock56", int'(active), 1);
    send_byte(COM);
    check_val("idle_com_out", int'(out_paralelo), 8'hBC);
    check_val("idle_com_valid", int'(valid_out), 0);

    // Random data while active
    repeat (12) send_byte(8'($urandom));

    // Reset mid-byte while active, then relock
    send_bit(1'($urandom)); send_bit(1'($urandom)); send_bit(1'($urandom));
    do_reset(1);
    check_val("midreset_active", int'(active), 0);
    check_val("midreset_out", int'(out_paralelo), 0);
    repeat (3) send_byte(COM);
    check_val("relock_3", int'(active), 0);
    send_byte(COM);
    check_val("relock_4", int'(active), 1);

    // Long non-COM run
    pulses = 0;
    repeat (16) send_byte(8'h11);
    check_val("gap_pulses", pulses, 16);
    check_val("gap_active", int'(active), LOSS_EN ? 0 : 1);

    // Randomized stream with noise and frequent COMs
    do_reset(2);
    for (int i = 0; i < 1 + int'($urandom_range(6)); i++) send_bit(1'($urandom));
    repeat (4) send_byte(COM);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) send_byte(COM);
      else send_byte(8'($urandom));
    end
    for (int i = 0; i < 60; i++) send_bit(1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
